// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter and sequencer between the load/store unit (requester 0)
// and the debug/loader port (requester 1) in front of the single-port data memory.
module dmem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_0,
    input  logic          req_valid_1,
    output logic          req_ready_0,
    output logic          req_ready_1,
    input  logic          req_we_0,
    input  logic          req_we_1,
    input  logic [AW-1:0] req_addr_0,
    input  logic [AW-1:0] req_addr_1,
    input  logic [DW-1:0] req_wdata_0,
    input  logic [DW-1:0] req_wdata_1,
    input  logic [3:0]    req_be_0,
    input  logic [3:0]    req_be_1,
    output logic          rsp_valid_0,
    output logic          rsp_valid_1,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        r_state;
    logic          r_lastGrant;
    logic          r_id;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_be;
    logic [DW-1:0] r_rdata;
    logic          r_rspValid0;
    logic          r_rspValid1;

    logic          w_grant0;
    logic          w_grant1;
    logic [DW-1:0] w_merged;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (rst && r_state == IDLE) begin
            if (req_valid_0 && req_valid_1) begin
                w_grant0 = r_lastGrant;
                w_grant1 = ~r_lastGrant;
            end else begin
                w_grant0 = req_valid_0;
                w_grant1 = req_valid_1;
            end
        end
    end

    // Disabled bytes keep the current memory contents (read-modify-write).
    always_comb begin
        w_merged = '0;
        for (int i = 0; i < 4; i++) begin
            w_merged[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : mem_rd[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b1;
            r_id        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_rdata     <= '0;
            r_rspValid0 <= 1'b0;
            r_rspValid1 <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_id        <= w_grant1;
                        r_lastGrant <= w_grant1;
                        r_we        <= w_grant1 ? req_we_1 : req_we_0;
                        r_addr      <= w_grant1 ? {req_addr_1[AW-1:2], 2'b00}
                                                : {req_addr_0[AW-1:2], 2'b00};
                        r_wdata     <= w_grant1 ? req_wdata_1 : req_wdata_0;
                        r_be        <= w_grant1 ? req_be_1 : req_be_0;
                        r_state     <= EXEC;
                    end
                end
                EXEC: begin
                    r_rdata     <= r_we ? '0 : mem_rd;
                    r_rspValid0 <= ~r_id;
                    r_rspValid1 <= r_id;
                    r_state     <= RESP;
                end
                RESP: begin
                    r_rspValid0 <= 1'b0;
                    r_rspValid1 <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_0 = w_grant0;
    assign req_ready_1 = w_grant1;
    assign rsp_valid_0 = r_rspValid0;
    assign rsp_valid_1 = r_rspValid1;
    assign rsp_rdata   = r_rdata;
    assign mem_a       = r_addr;
    // Gating with rst drops a write that is in flight when reset arrives.
    assign mem_we      = (r_state == EXEC) & r_we & rst;
    assign mem_wd      = (r_state == EXEC) ? w_merged : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a transaction-level model predicts grants,
// memory traffic and responses; a monitor pops expected responses as they appear.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic        req_we_0, req_we_1;
    logic [31:0] req_addr_0, req_addr_1;
    logic [31:0] req_wdata_0, req_wdata_1;
    logic [3:0]  req_be_0, req_be_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    dmem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_we_0(req_we_0), .req_we_1(req_we_1),
        .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
        .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
        .req_be_0(req_be_0), .req_be_1(req_be_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_rdata(rsp_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The memory the block drives: 1024 words, combinational read, posedge write.
    logic [31:0] tbMem [0:1023];
    assign mem_rd = tbMem[mem_a[11:2]];
    always @(posedge clk) if (mem_we) tbMem[mem_a[11:2]] <= mem_wd;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t expQ[$];

    // Reference model state: transaction phase (0 idle, 1 memory access, 2 response).
    logic [31:0] refMem [0:1023];
    int          mPhase = 0;
    int          mLast = 1;
    bit          mInReset = 1'b0;
    int          mId;
    bit          mWe;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    logic [3:0]  mBe;

    function automatic logic [31:0] mergeWord(input logic [31:0] oldW, input logic [31:0] newW,
                                              input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (oldW & ~mask) | (newW & mask);
    endfunction

    // Model: predicts readies and memory port activity each cycle, then advances.
    always @(negedge clk) begin
        if (started) begin
            int pick;
            bit e0, e1;
            e0 = 1'b0;
            e1 = 1'b0;
            pick = -1;
            if (rst && mPhase == 0) begin
                if (req_valid_0 && req_valid_1) pick = (mLast == 1) ? 0 : 1;
                else if (req_valid_0) pick = 0;
                else if (req_valid_1) pick = 1;
            end
            e0 = (pick == 0);
            e1 = (pick == 1);
            checks++;
            if (req_ready_0 !== e0 || req_ready_1 !== e1) begin
                errors++;
                $display("[TB] FAIL ready cyc=%0d got=%b%b exp=%b%b", cyc,
                         req_ready_1, req_ready_0, e1, e0);
            end
            if (mInReset) begin
                checks++;
                if (mem_a !== 32'h0 || mem_we !== 1'b0 || rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_outputs cyc=%0d mem_a=%h we=%b rsp=%b%b exp=0", cyc,
                             mem_a, mem_we, rsp_valid_1, rsp_valid_0);
                end
            end
            if (mPhase == 1) begin
                checks++;
                if (mem_a !== mAddr || mem_we !== (mWe && rst)) begin
                    errors++;
                    $display("[TB] FAIL exec_port cyc=%0d mem_a=%h we=%b exp a=%h we=%b", cyc,
                             mem_a, mem_we, mAddr, mWe && rst);
                end
                if (mWe && rst) begin
                    checks++;
                    if (mem_wd !== mergeWord(refMem[mAddr[11:2]], mWdata, mBe)) begin
                        errors++;
                        $display("[TB] FAIL mem_wd cyc=%0d got=%h exp=%h", cyc, mem_wd,
                                 mergeWord(refMem[mAddr[11:2]], mWdata, mBe));
                    end
                end
            end else begin
                checks++;
                if (mem_we !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stray_write cyc=%0d got=%b exp=0", cyc, mem_we);
                end
            end
            if (!rst) begin
                mPhase   = 0;
                mLast    = 1;
                mInReset = 1'b1;
            end else begin
                mInReset = 1'b0;
                if (mPhase == 0) begin
                    if (pick >= 0) begin
                        mId    = pick;
                        mLast  = pick;
                        mWe    = (pick == 0) ? req_we_0 : req_we_1;
                        mAddr  = ((pick == 0) ? req_addr_0 : req_addr_1) & 32'hFFFF_FFFC;
                        mWdata = (pick == 0) ? req_wdata_0 : req_wdata_1;
                        mBe    = (pick == 0) ? req_be_0 : req_be_1;
                        mPhase = 1;
                    end
                end else if (mPhase == 1) begin
                    exp_t e;
                    e.id  = mId;
                    e.due = cyc + 1;
                    if (mWe) begin
                        refMem[mAddr[11:2]] = mergeWord(refMem[mAddr[11:2]], mWdata, mBe);
                        e.data = 32'h0;
                    end else begin
                        e.data = refMem[mAddr[11:2]];
                    end
                    expQ.push_back(e);
                    mPhase = 2;
                end else begin
                    mPhase = 0;
                end
            end
        end
    end

    // Monitor: every response pulse must match the oldest expected one, on time.
    always @(negedge clk) begin
        if (started) begin
            if (rsp_valid_0 === 1'b1 || rsp_valid_1 === 1'b1) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_rsp cyc=%0d rsp=%b%b exp=none", cyc,
                             rsp_valid_1, rsp_valid_0);
                end else begin
                    exp_t e;
                    bit   idOk;
                    e = expQ.pop_front();
                    idOk = (e.id == 0) ? (rsp_valid_0 === 1'b1 && rsp_valid_1 === 1'b0)
                                       : (rsp_valid_1 === 1'b1 && rsp_valid_0 === 1'b0);
                    if (!idOk || rsp_rdata !== e.data || cyc != e.due) begin
                        errors++;
                        $display("[TB] FAIL rsp cyc=%0d rsp=%b%b data=%h exp id=%0d data=%h cyc=%0d",
                                 cyc, rsp_valid_1, rsp_valid_0, rsp_rdata, e.id, e.data, e.due);
                    end
                end
            end else if (expQ.size() > 0 && cyc >= expQ[0].due) begin
                checks++;
                errors++;
                $display("[TB] FAIL missing_rsp cyc=%0d got=none exp id=%0d data=%h",
                         cyc, expQ[0].id, expQ[0].data);
                void'(expQ.pop_front());
            end
        end
    end

    task automatic idleBoth();
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
    endtask

    // Drives one request and holds it until accepted; returns just after the handshake edge.
    task automatic applyStimulus(input int id, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        bit done;
        done = 1'b0;
        if (id == 0) begin
            req_valid_0 = 1'b1; req_we_0 = we; req_addr_0 = addr;
            req_wdata_0 = wdata; req_be_0 = be;
        end else begin
            req_valid_1 = 1'b1; req_we_1 = we; req_addr_1 = addr;
            req_wdata_1 = wdata; req_be_1 = be;
        end
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if ((id == 0 && req_ready_0) || (id == 1 && req_ready_1)) done = 1'b1;
        end
        if (!done) begin
            $display("[TB] FAIL handshake_timeout id=%0d got=no_ready exp=ready", id);
            $fatal(1, "[TB] handshake timeout");
        end
        @(posedge clk);
        #1;
        if (id == 0) req_valid_0 = 1'b0;
        else req_valid_1 = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        waitCycles(1);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            w = $urandom;
            tbMem[i]  = w;
            refMem[i] = w;
        end
        rst = 1'b0;
        req_valid_0 = 1'b1; req_valid_1 = 1'b0;
        req_we_0 = 1'b0; req_we_1 = 1'b0;
        req_addr_0 = 32'h0; req_addr_1 = 32'h0;
        req_wdata_0 = 32'h0; req_wdata_1 = 32'h0;
        req_be_0 = 4'h0; req_be_1 = 4'h0;

        // Reset held with a pending request.
        @(posedge clk);
        #1;
        started = 1'b1;
        waitCycles(3);
        idleBoth();
        rst = 1'b1;

        // Full-word store then load with an unaligned address.
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        applyStimulus(0, 1'b0, 32'h12, 32'h0, 4'h0);

        // Partial store over a known word, then reload.
        applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        applyStimulus(1, 1'b0, 32'h20, 32'h0, 4'h0);
        applyStimulus(0, 1'b1, 32'h24, 32'hCAFEF00D, 4'h0);

        // Contention from a fresh reset so requester 0 wins the first tie.
        waitCycles(3);
        pulseReset();
        req_we_0 = 1'b0; req_addr_0 = 32'h0;
        req_we_1 = 1'b0; req_addr_1 = 32'h4;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        begin
            int grants;
            grants = 0;
            for (int k = 0; k < 40 && grants < 4; k++) begin
                @(negedge clk);
                if (req_ready_0 || req_ready_1) grants++;
            end
            if (grants < 4) begin
                $display("[TB] FAIL contention_timeout got=%0d exp=4", grants);
                $fatal(1, "[TB] contention timeout");
            end
        end
        @(posedge clk);
        #1;
        idleBoth();

        // Reset during the write cycle of a store must drop it.
        waitCycles(3);
        applyStimulus(1, 1'b1, 32'h30, 32'h0, 4'hF);
        waitCycles(2);
        applyStimulus(1, 1'b1, 32'h30, 32'h55, 4'hF);
        rst = 1'b0;
        waitCycles(1);
        rst = 1'b1;
        applyStimulus(0, 1'b0, 32'h30, 32'h0, 4'h0);

        // Requester 1 alone after having won: both loads granted without stall.
        applyStimulus(1, 1'b0, 32'h10, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 32'h20, 32'h0, 4'h0);
        waitCycles(3);

        // Randomized traffic including addresses above 4 KiB and occasional resets.
        for (int k = 0; k < 600; k++) begin
            req_valid_0 = ($urandom_range(0, 1) == 1);
            req_valid_1 = ($urandom_range(0, 1) == 1);
            req_we_0 = ($urandom_range(0, 1) == 1);
            req_we_1 = ($urandom_range(0, 1) == 1);
            req_addr_0 = ($urandom_range(0, 3) == 0 ? 32'h1000 : 32'h0)
                         | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            req_addr_1 = ($urandom_range(0, 3) == 0 ? 32'h1000 : 32'h0)
                         | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            req_wdata_0 = $urandom;
            req_wdata_1 = $urandom;
            req_be_0 = 4'($urandom_range(0, 15));
            req_be_1 = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 63) != 0);
            waitCycles(1);
        end
        idleBoth();
        rst = 1'b1;
        waitCycles(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
